// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bus: fetch push side, decode pop side, flush and debug counters.
interface fetch_queue_if #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned PC_W    = 16,
  parameter int unsigned INSTR_W = 9
);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned STALL_W = 16;

  logic               in_valid;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               in_ready;
  logic               out_valid;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic               out_ready;
  logic               flush;
  logic [CNT_W-1:0]   count;
  logic [STALL_W-1:0] stall_cycles;

  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_instr, count, stall_cycles
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instr, count, stall_cycles
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: circular FIFO of {pc, instr} with
// single-cycle flush and a saturating fetch back-pressure counter.
module fetch_queue #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned PC_W    = 16,
  parameter int unsigned INSTR_W = 9
) (
  input  logic          CLK,
  input  logic          Init_n,
  fetch_queue_if.slave  bus
);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned STALL_W = 16;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [STALL_W-1:0] r_stall;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  // Ready/valid depend only on occupancy, so no out_ready -> in_ready path exists.
  assign w_in_ready  = (r_count != CNT_W'(DEPTH));
  assign w_out_valid = (r_count != CNT_W'(0));
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = w_out_valid;
  assign bus.out_pc       = r_mem[r_rd_ptr].pc;
  assign bus.out_instr    = r_mem[r_rd_ptr].instr;
  assign bus.count        = r_count;
  assign bus.stall_cycles = r_stall;

  always_ff @(posedge CLK) begin
    if (!Init_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_stall  <= '0;
      r_mem    <= '{default: '0};
    end else begin
      // Flush drops any same-cycle handshake; storage contents are left in place.
      if (bus.flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= {bus.in_pc, bus.in_instr};
          r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
      if (bus.in_valid && !w_in_ready && (r_stall != '1)) begin
        r_stall <= r_stall + STALL_W'(1);
      end
    end
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Small instruction buffer directly downstream of the fetch/PC stage. Decouples fetch from decode.
- Captures each {PC, instruction} pair produced by fetch into a DEPTH-entry FIFO and presents the oldest entry to decode with a valid/ready handshake.
- Supports a single-cycle flush when decode resolves a taken branch, so stale fetched instructions are discarded.
- Counts fetch back-pressure cycles for performance debug.

Parameters:
- DEPTH, 2, number of entries; power of two, minimum 2.
- PC_W, 16, program counter width; matches the fetch stage PC.
- INSTR_W, 9, instruction word width.

Ports:
- CLK  input  1  clock; all state changes on posedge.
- Init_n  input  1  synchronous active-low reset.
- in_valid  input  1  fetch presents a valid entry.
- in_pc  input  PC_W  PC of the presented instruction.
- in_instr  input  INSTR_W  instruction word at in_pc.
- in_ready  output  1  queue can accept an entry this cycle.
- out_valid  output  1  head entry valid.
- out_pc  output  PC_W  PC of head entry.
- out_instr  output  INSTR_W  instruction of head entry.
- out_ready  input  1  decode consumes head entry this cycle.
- flush  input  1  discard all entries (taken branch / jump resolved).
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- stall_cycles  output  16  saturating count of cycles with in_valid=1 and in_ready=0.

Behaviour:
- Reset: reset is sampled at posedge when Init_n=0. It sets read ptr, write ptr and count to 0, and stall_cycles to 0. As a result out_valid=0, in_ready=1, and out_pc/out_instr read 0. Entry storage is also cleared to 0.
- Reset mid-operation has priority over everything: any push, pop or flush in the same cycle is ignored.
- Storage: circular buffer; write ptr and read ptr are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- in_ready = (count != DEPTH). It is purely a function of state, with no combinational path from out_ready. A full queue therefore refuses a push even if a pop occurs the same cycle.
- out_valid = (count != 0). out_pc/out_instr are a combinational read of the entry at read ptr. They are don't-care when out_valid=0 but must not be X after reset.
- Push (in_valid && in_ready): write {in_pc, in_instr} at write ptr and increment write ptr. The entry becomes visible on out_* the next cycle at the earliest (latency 1, no bypass).
- Pop (out_valid && out_ready): increment read ptr.
- Count update: push only gives +1, pop only gives -1, push and pop together leave count unchanged, neither leaves it unchanged.
- out_ready while empty has no effect. in_valid while full has no effect, and the entry is not stored; fetch must hold it.
- Flush (Init_n=1, flush=1): next state is read ptr = write ptr = count = 0.
  - A push or pop handshake in the same cycle is discarded and counted as neither.
  - Entry storage is not cleared.
  - Cycle after flush: out_valid=0 and in_ready=1.
- stall_cycles: increments each cycle with in_valid=1 and in_ready=0, including flush cycles. It saturates at 16'hFFFF and is cleared only by reset, not by flush.
- Ordering: entries exit in exact push order. No reordering and no duplication.

Test Plan:
- Reset then idle: hold Init_n=0 for 2 cycles, then release with all inputs 0 → out_valid=0, in_ready=1, count=0, stall_cycles=0.
- Fill and drain, DEPTH=2:
  - Push (pc=0,instr=9'h011), then push (pc=1,instr=9'h022), with out_ready=0 → count=2, in_ready=0.
  - Hold in_valid with (pc=2) for 3 cycles → stall_cycles=3.
  - Raise out_ready → out_pc 0 then 1 on consecutive cycles, then pc=2 accepted; order 0,1,2 preserved.
- Simultaneous push/pop at count=1: queue holds pc=5, push pc=6 with out_ready=1 → count stays 1 and next head is pc=6.
- Flush with concurrent push: count=2 (pc=10,11), assert flush with in_valid pc=12 → next cycle count=0, out_valid=0. The pc=12 entry is never output; the following push of pc=40 (a branch target) appears as the next head.
- Wrap-around: stream 7 instructions pc=100..106 with out_ready=1 continuously → outputs are 100..106 in order, pointers wrap at least 3 times, and count never exceeds 1.
- Reset mid-operation: count=2 with stall_cycles=5, drive Init_n=0 together with in_valid=1 and out_ready=1 → next cycle count=0, stall_cycles=0, out_valid=0.
